// File: rtl/control_unit.sv
// Multi-cycle Moore sequencer: fetches 16-bit instructions, decodes them and drives the
// register-file / ALU / data-memory controls. Optional macro CU_ILLEGAL_TRAP_EN traps undefined opcodes.
module control_unit #(
  parameter int unsigned PC_W = 7
) (
  input  logic            Clk,
  input  logic            ResetN,
  input  logic [15:0]     IR_in,
  output logic [PC_W-1:0] PC_Addr,
  output logic [7:0]      D_Addr,
  output logic            D_Wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_addr,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic            RF_W_en,
  output logic [2:0]      ALU_s0,
  output logic [3:0]      State,
  output logic            Illegal
);

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;

  logic [7:0] d_addr_d;
  logic       d_wr_d, rf_s_d, rf_w_en_d;
  logic [3:0] rf_w_addr_d, rf_ra_addr_d, rf_rb_addr_d;
  logic [2:0] alu_s0_d;

  // Next state, IR and PC
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH: begin
        state_d = S_DECODE;
        ir_d    = IR_in;
        pc_d    = pc_q + PC_W'(1);
      end
      S_DECODE: begin
        case (ir_q[15:12])
          OP_NOOP:  state_d = S_NOOP;
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOADA;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
`ifdef CU_ILLEGAL_TRAP_EN
          default:  state_d = S_HALT;
`else
          default:  state_d = S_NOOP;
`endif
        endcase
      end
      S_LOADA:  state_d = S_LOADB;
      S_NOOP, S_LOADB, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Outputs decoded from the upcoming state so they can be registered without extra latency
  always_comb begin
    d_addr_d     = 8'h00;
    d_wr_d       = 1'b0;
    rf_s_d       = 1'b0;
    rf_w_addr_d  = 4'h0;
    rf_ra_addr_d = 4'h0;
    rf_rb_addr_d = 4'h0;
    rf_w_en_d    = 1'b0;
    alu_s0_d     = ALU_IDLE;
    case (state_d)
      S_STORE: begin
        d_addr_d     = ir_d[7:0];
        rf_ra_addr_d = ir_d[11:8];
        d_wr_d       = 1'b1;
      end
      S_LOADA:  d_addr_d = ir_d[11:4];
      S_LOADB: begin
        d_addr_d    = ir_d[11:4];
        rf_s_d      = 1'b1;
        rf_w_addr_d = ir_d[3:0];
        rf_w_en_d   = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_ra_addr_d = ir_d[11:8];
        rf_rb_addr_d = ir_d[7:4];
        rf_w_addr_d  = ir_d[3:0];
        alu_s0_d     = (state_d == S_ADD) ? ALU_ADD : ALU_SUB;
        rf_w_en_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= S_INIT;
      ir_q       <= 16'h0000;
      pc_q       <= '0;
      D_Addr     <= 8'h00;
      D_Wr       <= 1'b0;
      RF_s       <= 1'b0;
      RF_W_addr  <= 4'h0;
      RF_Ra_addr <= 4'h0;
      RF_Rb_addr <= 4'h0;
      RF_W_en    <= 1'b0;
      ALU_s0     <= ALU_IDLE;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      D_Addr     <= d_addr_d;
      D_Wr       <= d_wr_d;
      RF_s       <= rf_s_d;
      RF_W_addr  <= rf_w_addr_d;
      RF_Ra_addr <= rf_ra_addr_d;
      RF_Rb_addr <= rf_rb_addr_d;
      RF_W_en    <= rf_w_en_d;
      ALU_s0     <= alu_s0_d;
    end
  end

  assign PC_Addr = pc_q;
  assign State   = state_q;

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky flag raised on the Decode edge that traps an undefined opcode
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) illegal_q <= 1'b0;
    else if (state_q == S_DECODE && ir_q[15:12] > OP_HALT) illegal_q <= 1'b1;
  end

  assign Illegal = illegal_q;
`else
  assign Illegal = 1'b0;
`endif

endmodule
